// File: rtl/tc_burst_pkg.sv
// Shared types and helpers for the fast-RAM burst sequencer.
// Address wrap behaviour is selected in the top by TC_BURST_WRAP_EN.
package tc_burst_pkg;

  localparam int ADDR_W       = 16;
  localparam int BURST_DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_e;

  // Step one word; with wrap enabled, DEPTH-1 rolls over to 0.
  function automatic logic [ADDR_W-1:0] next_addr(
    input logic [ADDR_W-1:0] a,
    input int unsigned       depth,
    input logic              wrap
  );
    logic [ADDR_W:0] nx;
    nx = {1'b0, a} + 17'd1;
    if (wrap && (nx >= 17'(depth))) begin
      nx = '0;
    end
    return nx[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/tc_burst_rd_slot.sv
// Single-entry registered output slot for read beats.
// free_o is high when the slot is empty or is being drained this cycle.
module tc_burst_rd_slot
  import tc_burst_pkg::*;
#(
  parameter int DATA_W = BURST_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              free_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign free_o  = !valid_q || ready_i;

  // Capture a new beat on load; otherwise empty the slot once consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/tc_ram_burst_ctrl.sv
// Burst sequencer in front of the fast RAM: one request per handshake, one beat per cycle.
// Define TC_BURST_WRAP_EN to let bursts wrap DEPTH-1 -> 0 instead of rejecting them.
module tc_ram_burst_ctrl
  import tc_burst_pkg::*;
#(
  parameter int unsigned DEPTH  = 256,
  parameter int          DATA_W = BURST_DATA_W,
  parameter int          LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [15:0]       req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              err,
  output logic              ram_load,
  output logic              ram_save,
  output logic [15:0]       ram_address,
  output logic [DATA_W-1:0] ram_in0,
  input  logic [DATA_W-1:0] ram_out0
);

`ifdef TC_BURST_WRAP_EN
  localparam logic WRAP = 1'b1;
`else
  localparam logic WRAP = 1'b0;
`endif

  localparam logic [16:0] DEPTH17 = 17'(DEPTH);

  state_e            state_q, state_d;
  logic [15:0]       addr_q, addr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  logic              slot_free;
  logic              req_fire;
  logic              req_bad;
  logic              accept;
  logic              last;
  logic              wr_beat;
  logic              rd_beat;
  logic [16:0]       base17;

  assign base17   = {1'b0, req_addr};
  assign req_fire = req_valid && req_ready;

`ifdef TC_BURST_WRAP_EN
  assign req_bad = (base17 >= DEPTH17);
`else
  logic [16:0] end17;
  assign end17   = base17 + 17'(req_len);
  assign req_bad = (base17 >= DEPTH17) || (end17 > (DEPTH17 - 17'd1));
`endif

  assign accept  = req_fire && !req_bad;
  assign last    = (cnt_q == '0);
  assign wr_beat = (state_q == WRITE) && wr_valid;
  assign rd_beat = (state_q == READ) && slot_free;

  assign busy = (state_q != IDLE);
  assign err  = err_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: leave IDLE on a legal request, return after the last beat.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = req_write ? WRITE : READ;
        end
      end
      WRITE: begin
        if (wr_valid && last) begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (slot_free && last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode: RAM strobes and handshake readies per state.
  always_comb begin
    req_ready   = 1'b0;
    wr_ready    = 1'b0;
    ram_load    = 1'b0;
    ram_save    = 1'b0;
    ram_address = '0;
    ram_in0     = '0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
      end
      WRITE: begin
        wr_ready    = 1'b1;
        ram_save    = wr_valid;
        ram_address = addr_q;
        ram_in0     = wr_data;
      end
      READ: begin
        ram_load    = slot_free;
        ram_address = addr_q;
      end
      default: begin
        req_ready = 1'b0;
      end
    endcase
  end

  // Address/beat-counter next values and the reject pulse.
  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    err_d  = req_fire && req_bad;
    if (accept) begin
      addr_d = req_addr;
      cnt_d  = req_len;
    end else if (wr_beat || rd_beat) begin
      addr_d = next_addr(addr_q, DEPTH, WRAP);
      cnt_d  = cnt_q - 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  tc_burst_rd_slot #(
    .DATA_W (DATA_W)
  ) u_slot (
    .clk     (clk),
    .rst     (rst),
    .load_i  (rd_beat),
    .data_i  (ram_out0),
    .ready_i (rd_ready),
    .valid_o (rd_valid),
    .data_o  (rd_data),
    .free_o  (slot_free)
  );

endmodule

// File: tb/tb_tc_ram_burst_ctrl.sv
// Scoreboard bench for tc_ram_burst_ctrl with a behavioural RAM model.
// Default build covers the non-wrapping configuration; TC_BURST_WRAP_EN switches case 4.
module tb_tc_ram_burst_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [7:0]  req_len;
  logic        wr_valid;
  logic        wr_ready;
  logic [63:0] wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [63:0] rd_data;
  logic        busy;
  logic        err;
  logic        ram_load;
  logic        ram_save;
  logic [15:0] ram_address;
  logic [63:0] ram_in0;
  logic [63:0] ram_out0;

  int errors = 0;
  int checks = 0;
  int exp_err = 0;

  logic [79:0] exp_wr[$];
  logic [63:0] exp_rd[$];
  logic [63:0] mem     [256];
  logic [63:0] exp_mem [256];

  tc_ram_burst_ctrl #(
    .DEPTH  (256),
    .DATA_W (64),
    .LEN_W  (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_len     (req_len),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .busy        (busy),
    .err         (err),
    .ram_load    (ram_load),
    .ram_save    (ram_save),
    .ram_address (ram_address),
    .ram_in0     (ram_in0),
    .ram_out0    (ram_out0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: combinational read, write on negedge.
  assign ram_out0 = (ram_address < 16'd256) ? mem[ram_address[7:0]] : 64'd0;
  always @(negedge clk) begin
    if (ram_save && (ram_address < 16'd256)) mem[ram_address[7:0]] <= ram_in0;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a beat.
  always @(negedge clk) begin
    if (!rst) begin
      if (ram_save && ram_load) begin
        checks++; errors++;
        $display("FAIL load_save_both: got 1 expected 0");
      end
      if (ram_save) begin
        checks++;
        if (exp_wr.size() == 0) begin
          errors++;
          $display("FAIL unexpected_save: got addr %0h expected none", ram_address);
        end else begin
          logic [79:0] e;
          e = exp_wr.pop_front();
          if ({ram_address, ram_in0} !== e) begin
            errors++;
            $display("FAIL save_beat: got %0h/%0h expected %0h/%0h",
                     ram_address, ram_in0, e[79:64], e[63:0]);
          end
        end
      end
      if (rd_valid && rd_ready) begin
        checks++;
        if (exp_rd.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rd: got %0h expected none", rd_data);
        end else begin
          logic [63:0] e;
          e = exp_rd.pop_front();
          if (rd_data !== e) begin
            errors++;
            $display("FAIL rd_beat: got %0h expected %0h", rd_data, e);
          end
        end
      end
      if (err) begin
        checks++;
        if (exp_err == 0) begin
          errors++;
          $display("FAIL unexpected_err: got 1 expected 0");
        end else begin
          exp_err--;
        end
      end
    end
  end

  task automatic send_req(input logic w, input logic [15:0] a, input logic [7:0] l);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_len   = l;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL req_timeout: got req_ready 0 expected 1");
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic write_burst(input logic [15:0] a, input logic [7:0] l,
                             input logic [63:0] d0, input bit toggle);
    logic [15:0] ad;
    int i;
    int c;
    bit v;
    ad = a; i = 0; c = 0;
    send_req(1'b1, a, l);
    while (i <= int'(l)) begin
      v = toggle ? (c % 2 == 0) : 1'b1;
      wr_valid = v;
      wr_data  = d0 + 64'(i);
      if (v) begin
        exp_wr.push_back({ad, wr_data});
        exp_mem[ad[7:0]] = wr_data;
      end else begin
        @(negedge clk);
        chk("wr_stall_save", 64'(ram_save), 64'd0);
        chk("wr_stall_addr", 64'(ram_address), 64'(ad));
      end
      @(posedge clk); #1;
      if (v) begin
        ad = (ad == 16'd255) ? 16'd0 : ad + 16'd1;
        i++;
      end
      c++;
    end
    wr_valid = 1'b0;
    chk("wr_busy_done", 64'(busy), 64'd0);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_rd.size() != 0 || busy) && n < 100) begin
      @(posedge clk); n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_rd.size());
    end
    #1;
  endtask

  task automatic read_burst(input logic [15:0] a, input logic [7:0] l, input bit lat);
    for (int i = 0; i <= int'(l); i++) exp_rd.push_back(exp_mem[(int'(a) + i) % 256]);
    rd_ready = 1'b1;
    send_req(1'b0, a, l);
    if (lat) begin
      @(negedge clk);
      chk("lat_load", 64'(ram_load), 64'd1);
      chk("lat_addr", 64'(ram_address), 64'(a));
      chk("lat_novalid", 64'(rd_valid), 64'd0);
      @(negedge clk);
      chk("lat_valid", 64'(rd_valid), 64'd1);
    end
    wait_drain();
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 0; req_write = 0; req_addr = 0; req_len = 0;
    wr_valid = 0; wr_data = 0; rd_ready = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 64'd0;
      exp_mem[i] = 64'd0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_data", rd_data, 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_strobes", 64'({ram_load, ram_save}), 64'd0);
    chk("rst_addr", 64'(ram_address), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;

    // 1: contiguous write, 2: read back with latency check
    write_burst(16'h10, 8'd3, 64'hA0, 1'b0);
    read_burst(16'h10, 8'd3, 1'b1);

    // 3: read with back-pressure at beat 2
    for (int i = 0; i < 4; i++) exp_rd.push_back(exp_mem[16 + i]);
    rd_ready = 1'b1;
    send_req(1'b0, 16'h10, 8'd3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rd_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_data", rd_data, 64'hA1);
      chk("stall_addr", 64'(ram_address), 64'h12);
      chk("stall_noload", 64'(ram_load), 64'd0);
      @(posedge clk); #1;
    end
    rd_ready = 1'b1;
    wait_drain();

    // 4: burst crossing the top of the RAM
`ifdef TC_BURST_WRAP_EN
    write_burst(16'hFE, 8'd3, 64'hC0, 1'b0);
    read_burst(16'hFE, 8'd3, 1'b0);
`else
    exp_err++;
    send_req(1'b0, 16'hFE, 8'd3);
    @(negedge clk);
    chk("cross_err", 64'(err), 64'd1);
    chk("cross_idle", 64'(busy), 64'd0);
    chk("cross_noload", 64'(ram_load), 64'd0);
    @(negedge clk);
    chk("cross_err_drop", 64'(err), 64'd0);
    @(posedge clk); #1;
`endif
    // base beyond DEPTH is always rejected
    exp_err++;
    send_req(1'b1, 16'h100, 8'd0);
    @(negedge clk);
    chk("oob_err", 64'(err), 64'd1);
    chk("oob_idle", 64'(busy), 64'd0);
    @(posedge clk); #1;
    // burst ending exactly at DEPTH-1 is legal
    write_burst(16'hFC, 8'd3, 64'hB0, 1'b0);
    read_burst(16'hFC, 8'd3, 1'b0);

    // 5: async reset in the middle of a write
    send_req(1'b1, 16'h20, 8'd3);
    wr_valid = 1'b1;
    wr_data  = 64'hD0;
    exp_wr.push_back({16'h20, 64'hD0});
    exp_mem[8'h20] = 64'hD0;
    @(posedge clk); #1;
    wr_data = 64'hD1;
    #2 rst = 1'b1;
    #1;
    chk("arst_save", 64'(ram_save), 64'd0);
    chk("arst_addr", 64'(ram_address), 64'd0);
    chk("arst_in0", ram_in0, 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_wr_ready", 64'(wr_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    wr_valid = 1'b0;
    chk("arst_req_ready", 64'(req_ready), 64'd1);
    write_burst(16'h20, 8'd1, 64'hE0, 1'b0);
    read_burst(16'h20, 8'd2, 1'b0);

    // 6: write with gapped wr_valid
    write_burst(16'h40, 8'd2, 64'hF0, 1'b1);
    read_burst(16'h40, 8'd2, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("end_wr_queue", 64'(exp_wr.size()), 64'd0);
    chk("end_rd_queue", 64'(exp_rd.size()), 64'd0);
    chk("end_err_queue", 64'(exp_err), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
